// File: rtl/sram_to_sram_host_pkg.sv
// Shared definitions for the SRAM-to-SRAM host.
//   state_e         : controller FSM states
//   TIMEOUT_CYCLES  : WAIT-state timeout, in cycles with cke=1
//   SKID_DEPTH      : number of entries in the unload skid buffer
package sram_to_sram_host_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        UNLOAD
    } state_e;

    localparam logic [15:0] TIMEOUT_CYCLES = 16'hFFFF;
    localparam int          SKID_DEPTH     = 2;

endpackage

// File: rtl/sram_to_sram_host_skid.sv
// Two-entry skid buffer for the unload path. Each entry carries both data
// lanes and the last flag. The producer must only push when there is room.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   cke                   clock enable; all state holds when 0
//   in_valid              push one entry (in_data0/in_data1/in_last)
//   out_valid/out_ready   head-of-buffer handshake
//   out_data0/1, out_last head entry, forced to 0 while empty
//   count                 current number of stored entries
module sram_to_sram_host_skid
    import sram_to_sram_host_pkg::*;
#(
    parameter type data_t = logic [63:0]
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cke,
    input  logic       in_valid,
    input  data_t      in_data0,
    input  data_t      in_data1,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output data_t      out_data0,
    output data_t      out_data1,
    output logic       out_last,
    output logic [1:0] count
);

    typedef struct packed {
        data_t data0;
        data_t data1;
        logic  last;
    } entry_t;

    entry_t     mem_q [SKID_DEPTH];
    entry_t     head;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       push, pop;

    assign push = in_valid & cke;
    assign pop  = out_valid & out_ready & cke;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
        if (push) wr_ptr_d = ~wr_ptr_q;
        if (pop)  rd_ptr_d = ~rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count_q says which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{data0: in_data0, data1: in_data1, last: in_last};
    end

    assign head      = mem_q[rd_ptr_q];
    assign out_valid = (count_q != 2'd0);
    assign out_data0 = out_valid ? head.data0 : '0;
    assign out_data1 = out_valid ? head.data1 : '0;
    assign out_last  = out_valid & head.last;
    assign count     = count_q;

endmodule

// File: rtl/sram_to_sram_host.sv
// Host controller: loads a stream into two source SRAMs, kicks the core,
// waits for completion, then unloads two result SRAMs onto a stream.
// Optional WAIT timeout: define SRAM_TO_SRAM_HOST_TIMEOUT_EN.
// Ports:
//   clk, reset, cke                 clock, sync active-high reset, clock enable
//   param_len                       transfer length in words minus 1
//   s_data0/1, s_valid, s_ready     load stream
//   core_start, core_done           processing core handshake
//   mem0/1_wen, _waddr, _wdata      source SRAM write ports
//   mem2/3_ren, _raddr, _rdata      result SRAM read ports (1-cycle latency)
//   m_data0/1, m_last, m_valid, m_ready  unload stream
//   busy, error                     FSM not idle, sticky timeout flag
module sram_to_sram_host
    import sram_to_sram_host_pkg::*;
#(
    parameter int  ADDR_BITS = 10,
    parameter type addr_t    = logic [ADDR_BITS-1:0],
    parameter int  DATA_BITS = 64,
    parameter type data_t    = logic [DATA_BITS-1:0]
) (
    input  logic                 reset,
    input  logic                 clk,
    input  logic                 cke,
    input  logic [ADDR_BITS-1:0] param_len,
    input  logic [DATA_BITS-1:0] s_data0,
    input  logic [DATA_BITS-1:0] s_data1,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic                 core_start,
    input  logic                 core_done,
    output logic                 mem0_wen,
    output logic                 mem1_wen,
    output logic [ADDR_BITS-1:0] mem0_waddr,
    output logic [ADDR_BITS-1:0] mem1_waddr,
    output logic [DATA_BITS-1:0] mem0_wdata,
    output logic [DATA_BITS-1:0] mem1_wdata,
    output logic                 mem2_ren,
    output logic                 mem3_ren,
    output logic [ADDR_BITS-1:0] mem2_raddr,
    output logic [ADDR_BITS-1:0] mem3_raddr,
    input  logic [DATA_BITS-1:0] mem2_rdata,
    input  logic [DATA_BITS-1:0] mem3_rdata,
    output logic [DATA_BITS-1:0] m_data0,
    output logic [DATA_BITS-1:0] m_data1,
    output logic                 m_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 busy,
    output logic                 error
);

    state_e     state_q, state_d;
    addr_t      len_q, len_d;
    addr_t      waddr_q, waddr_d;
    addr_t      raddr_q, raddr_d;
    logic       reads_done_q, reads_done_d;  // final address already read
    logic       inflight_q, inflight_d;      // read issued last enabled cycle
    logic       rlast_q, rlast_d;            // that read was the final address
    logic       wen, ren, skid_pop, room;
    logic [1:0] skid_count;
    logic [2:0] occupancy;

`ifdef SRAM_TO_SRAM_HOST_TIMEOUT_EN
    logic [15:0] timer_q, timer_d;
    logic        error_q, error_d;
`endif

    // Entries that will be held after this edge: stored + arriving - leaving.
    // Counting the pop lets a read issue into a full buffer that is draining.
    assign skid_pop  = m_valid & m_ready & cke;
    assign occupancy = {1'b0, skid_count} + {2'b00, inflight_q} - {2'b00, skid_pop};
    assign room      = occupancy < 3'(SKID_DEPTH);

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        waddr_d      = waddr_q;
        raddr_d      = raddr_q;
        reads_done_d = reads_done_q;
        inflight_d   = inflight_q;
        rlast_d      = rlast_q;
        wen          = 1'b0;
        ren          = 1'b0;
        s_ready      = 1'b0;
        core_start   = 1'b0;
`ifdef SRAM_TO_SRAM_HOST_TIMEOUT_EN
        timer_d      = timer_q;
        error_d      = error_q;
`endif
        case (state_q)
            IDLE: begin
                if (cke && s_valid) begin
                    state_d      = LOAD;
                    len_d        = param_len;
                    waddr_d      = '0;
                    raddr_d      = '0;
                    reads_done_d = 1'b0;
                end
            end
            LOAD: begin
                s_ready = 1'b1;
                if (cke && s_valid) begin
                    wen     = 1'b1;
                    waddr_d = waddr_q + addr_t'(1);
                    if (waddr_q == len_q) state_d = START;
                end
            end
            START: begin
                core_start = 1'b1;
                if (cke) begin
                    state_d = WAIT;
`ifdef SRAM_TO_SRAM_HOST_TIMEOUT_EN
                    timer_d = '0;
`endif
                end
            end
            WAIT: begin
                if (cke) begin
                    if (core_done) begin
                        state_d = UNLOAD;
`ifdef SRAM_TO_SRAM_HOST_TIMEOUT_EN
                    end else if (timer_q == TIMEOUT_CYCLES - 16'd1) begin
                        state_d = IDLE;
                        error_d = 1'b1;
                    end else begin
                        timer_d = timer_q + 16'd1;
`endif
                    end
                end
            end
            UNLOAD: begin
                if (cke && !reads_done_q && room) begin
                    ren     = 1'b1;
                    raddr_d = raddr_q + addr_t'(1);
                    rlast_d = (raddr_q == len_q);
                    if (raddr_q == len_q) reads_done_d = 1'b1;
                end
                if (skid_pop && m_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (cke) inflight_d = ren;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            len_q        <= '0;
            waddr_q      <= '0;
            raddr_q      <= '0;
            reads_done_q <= 1'b0;
            inflight_q   <= 1'b0;
            rlast_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            waddr_q      <= waddr_d;
            raddr_q      <= raddr_d;
            reads_done_q <= reads_done_d;
            inflight_q   <= inflight_d;
            rlast_q      <= rlast_d;
        end
    end

`ifdef SRAM_TO_SRAM_HOST_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= '0;
            error_q <= 1'b0;
        end else begin
            timer_q <= timer_d;
            error_q <= error_d;
        end
    end
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    sram_to_sram_host_skid #(.data_t(data_t)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .cke       (cke),
        .in_valid  (inflight_q),
        .in_data0  (mem2_rdata),
        .in_data1  (mem3_rdata),
        .in_last   (rlast_q),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .out_data0 (m_data0),
        .out_data1 (m_data1),
        .out_last  (m_last),
        .count     (skid_count)
    );

    assign mem0_wen   = wen;
    assign mem1_wen   = wen;
    assign mem0_waddr = waddr_q;
    assign mem1_waddr = waddr_q;
    assign mem0_wdata = wen ? s_data0 : '0;
    assign mem1_wdata = wen ? s_data1 : '0;
    assign mem2_ren   = ren;
    assign mem3_ren   = ren;
    assign mem2_raddr = raddr_q;
    assign mem3_raddr = raddr_q;
    assign busy       = (state_q != IDLE);

endmodule
